led_frame_arbiter: RTL and testbench



---
 rtl/led_pkg.sv | 22 ++
 rtl/led_pwm_bank.sv | 40 ++++
 rtl/led_frame_arbiter.sv | 106 ++++++++++
 tb/tb_led_frame_arbiter.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/led_pkg.sv
// Shared types and defaults for the LED PWM bank and its frame arbiter.
package led_pkg;

    localparam int DEF_CHANNELS   = 8;
    localparam int DEF_LEVEL_BITS = 4;

    typedef logic [DEF_LEVEL_BITS-1:0] level_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } arb_state_e;

    // Channel j lives at bits [j*LEVEL_BITS +: LEVEL_BITS] of a packed frame.
    function automatic level_t frame_level(
        input logic [DEF_CHANNELS*DEF_LEVEL_BITS-1:0] frame,
        input int unsigned                            j
    );
        return frame[j*DEF_LEVEL_BITS +: DEF_LEVEL_BITS];
    endfunction

endpackage

// File: rtl/led_pwm_bank.sv
// Free-running duty counter and registered per-channel PWM comparators.
module led_pwm_bank #(
    parameter int CHANNELS   = 8,
    parameter int LEVEL_BITS = 4
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [CHANNELS*LEVEL_BITS-1:0] levels,
    output logic                           period_start,
    output logic                           boundary,
    output logic [CHANNELS-1:0]            led
);

    logic [LEVEL_BITS-1:0] duty_q, duty_d;
    logic [CHANNELS-1:0]   led_q, led_d;

    always_comb begin
        duty_d = duty_q + 1'b1;
        led_d  = '0;
        for (int j = 0; j < CHANNELS; j++) begin
            led_d[j] = (duty_q < levels[j*LEVEL_BITS +: LEVEL_BITS]);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            duty_q <= '0;
            led_q  <= '0;
        end else begin
            duty_q <= duty_d;
            led_q  <= led_d;
        end
    end

    assign period_start = (duty_q == '0);
    // The edge leaving duty==max is the only point where the frame may change.
    assign boundary     = (duty_q == '1);
    assign led          = led_q;

endmodule

// File: rtl/led_frame_arbiter.sv
// Round-robin arbiter sharing the LED PWM bank between two frame sources,
// switching frames only on PWM period boundaries.
module led_frame_arbiter
    import led_pkg::*;
#(
    parameter int CHANNELS      = DEF_CHANNELS,
    parameter int LEVEL_BITS    = DEF_LEVEL_BITS,
    parameter int DWELL_PERIODS = 64
) (
    input  logic                           oneMHzClock,
    input  logic                           reset,
    input  logic [1:0]                     req,
    input  logic [CHANNELS*LEVEL_BITS-1:0] frame0,
    input  logic [CHANNELS*LEVEL_BITS-1:0] frame1,
    output logic [1:0]                     ack,
    output logic                           grant_id,
    output logic                           busy,
    output logic                           period_start,
    output logic [CHANNELS-1:0]            LED
);

    localparam int DW = (DWELL_PERIODS > 1) ? $clog2(DWELL_PERIODS) : 1;
    localparam logic [DW-1:0] DWELL_LOAD = DW'(DWELL_PERIODS - 1);

    arb_state_e                     state_q, state_d;
    logic [DW-1:0]                  dwell_q, dwell_d;
    logic                           grant_q, grant_d;
    logic                           last_q, last_d;
    logic [1:0]                     ack_q, ack_d;
    logic [CHANNELS*LEVEL_BITS-1:0] level_q, level_d;

    logic boundary;
    logic win;
    logic arb;

    led_pwm_bank #(
        .CHANNELS  (CHANNELS),
        .LEVEL_BITS(LEVEL_BITS)
    ) u_pwm (
        .clk         (oneMHzClock),
        .reset       (reset),
        .levels      (level_q),
        .period_start(period_start),
        .boundary    (boundary),
        .led         (LED)
    );

    // Tie goes to whoever did not win last; a lone requester always wins.
    assign win = (req == 2'b11) ? ~last_q : req[1];

    always_comb begin
        state_d = state_q;
        dwell_d = dwell_q;
        grant_d = grant_q;
        last_d  = last_q;
        level_d = level_q;
        ack_d   = '0;
        arb     = 1'b0;
        if (boundary) begin
            case (state_q)
                ST_IDLE: arb = |req;
                ST_HOLD: begin
                    if (dwell_q != '0) begin
                        dwell_d = dwell_q - 1'b1;
                    end else if (|req) begin
                        arb = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
        if (arb) begin
            state_d    = ST_HOLD;
            grant_d    = win;
            last_d     = win;
            dwell_d    = DWELL_LOAD;
            ack_d[win] = 1'b1;
            level_d    = win ? frame1 : frame0;
        end
    end

    always_ff @(posedge oneMHzClock) begin
        if (reset) begin
            state_q <= ST_IDLE;
            dwell_q <= '0;
            grant_q <= 1'b0;
            last_q  <= 1'b1;
            ack_q   <= '0;
            level_q <= '0;
        end else begin
            state_q <= state_d;
            dwell_q <= dwell_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            ack_q   <= ack_d;
            level_q <= level_d;
        end
    end

    assign ack      = ack_q;
    assign grant_id = grant_q;
    assign busy     = (state_q == ST_HOLD);

endmodule

// File: tb/tb_led_frame_arbiter.sv
// Directed scenario bench for led_frame_arbiter at default parameters.
module tb_led_frame_arbiter;
    import led_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  req;
    logic [31:0] frame0, frame1;
    logic [1:0]  ack;
    logic        grant_id, busy, period_start;
    logic [7:0]  led;

    int          checks = 0;
    int          errors = 0;
    logic [3:0]  ph;      // expected duty value in the current cycle

    always #5 clk = ~clk;

    led_frame_arbiter dut (
        .oneMHzClock (clk),
        .reset       (reset),
        .req         (req),
        .frame0      (frame0),
        .frame1      (frame1),
        .ack         (ack),
        .grant_id    (grant_id),
        .busy        (busy),
        .period_start(period_start),
        .LED         (led)
    );

    // Expected LED in a cycle whose duty is p: compare result of duty p-1.
    function automatic logic [7:0] exp_led(input logic [31:0] frame, input logic [3:0] p);
        logic [3:0] pd;
        logic [7:0] r;
        pd = p - 4'd1;
        r  = '0;
        for (int j = 0; j < 8; j++) r[j] = (pd < frame_level(frame, j));
        return r;
    endfunction

    task automatic tick();
        logic r;
        r = reset;
        @(posedge clk);
        #1;
        if (r) ph = 4'd0;
        else   ph = ph + 4'd1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        req   = 2'b00;
        repeat (3) tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        int ps_cnt;
        int led_bad;
        frame0 = '0;
        frame1 = '0;
        do_reset();
        checks++; if (led !== 8'h00)  begin errors++; $display("FAIL reset_led got=%h exp=00", led); end
        checks++; if (ack !== 2'b00)  begin errors++; $display("FAIL reset_ack got=%b exp=00", ack); end
        checks++; if (busy !== 1'b0)  begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (grant_id !== 1'b0) begin errors++; $display("FAIL reset_grant got=%b exp=0", grant_id); end
        checks++; if (period_start !== 1'b1) begin errors++; $display("FAIL reset_pstart got=%b exp=1", period_start); end
        ps_cnt  = 0;
        led_bad = 0;
        for (int i = 1; i <= 32; i++) begin
            tick();
            if (period_start) ps_cnt++;
            if (period_start !== (i % 16 == 0)) led_bad++;
            if (led !== 8'h00 || busy !== 1'b0 || ack !== 2'b00) led_bad++;
        end
        checks++; if (ps_cnt != 2)  begin errors++; $display("FAIL idle_pstart_count got=%0d exp=2", ps_cnt); end
        checks++; if (led_bad != 0) begin errors++; $display("FAIL idle_outputs bad_cycles=%0d exp=0", led_bad); end
    endtask

    task automatic test_single();
        int early;
        int bad;
        int busy_cnt;
        do_reset();
        frame0 = 32'h8888_8888;
        req    = 2'b01;
        early  = 0;
        for (int i = 1; i <= 15; i++) begin
            tick();
            if (ack !== 2'b00) early++;
        end
        checks++; if (early != 0) begin errors++; $display("FAIL single_early_ack cycles=%0d exp=0", early); end
        tick();
        checks++; if (ack !== 2'b01) begin errors++; $display("FAIL single_ack got=%b exp=01", ack); end
        checks++; if (period_start !== 1'b1) begin errors++; $display("FAIL single_ack_pstart got=%b exp=1", period_start); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy got=%b exp=1", busy); end
        req      = 2'b00;
        busy_cnt = 1;
        bad      = 0;
        for (int i = 1; i <= 32; i++) begin
            tick();
            if (ack !== 2'b00) bad++;
            if (led !== exp_led(frame0, ph)) bad++;
            if (busy) busy_cnt++;
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL single_pwm8 bad_cycles=%0d exp=0", bad); end
        for (int i = 0; i < 2000 && busy; i++) begin
            tick();
            if (busy) busy_cnt++;
        end
        checks++; if (busy_cnt != 1024) begin errors++; $display("FAIL single_busy_len got=%0d exp=1024", busy_cnt); end
        while (ph != 4'd1) tick();
        checks++; if (led !== 8'hFF) begin errors++; $display("FAIL single_retain got=%h exp=ff", led); end
    endtask

    task automatic test_back_to_back();
        int bad;
        do_reset();
        frame0 = 32'h3333_3333;
        frame1 = 32'hCCCC_CCCC;
        req    = 2'b11;
        repeat (16) tick();
        checks++; if (ack !== 2'b01 || grant_id !== 1'b0) begin errors++; $display("FAIL b2b_first ack=%b grant=%b exp ack=01 grant=0", ack, grant_id); end
        bad = 0;
        for (int i = 1; i < 1024; i++) begin
            tick();
            if (ack !== 2'b00 || busy !== 1'b1 || grant_id !== 1'b0) bad++;
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL b2b_dwell bad_cycles=%0d exp=0", bad); end
        tick();
        checks++; if (ack !== 2'b10 || grant_id !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL b2b_second ack=%b grant=%b busy=%b exp 10/1/1", ack, grant_id, busy); end
        repeat (4) tick();
        checks++; if (led !== 8'hFF) begin errors++; $display("FAIL b2b_frame1 got=%h exp=ff", led); end
        req = 2'b00;
    endtask

    task automatic test_mid_dwell();
        int acks;
        do_reset();
        frame0 = 32'h1111_1111;
        frame1 = 32'h0000_0000;
        req    = 2'b01;
        repeat (16) tick();
        checks++; if (ack !== 2'b01) begin errors++; $display("FAIL mid_ack0 got=%b exp=01", ack); end
        req  = 2'b00;
        acks = 0;
        tick();
        checks++; if (led !== 8'hFF) begin errors++; $display("FAIL mid_lvl1_on got=%h exp=ff", led); end
        tick();
        checks++; if (led !== 8'h00) begin errors++; $display("FAIL mid_lvl1_off got=%h exp=00", led); end
        for (int i = 3; i < 1024; i++) begin
            if (i == 100) begin req = 2'b10; frame1 = 32'hFFFF_FFFF; end
            if (i == 1020) frame1 = 32'h5555_5555;
            tick();
            if (ack !== 2'b00) acks++;
        end
        checks++; if (acks != 0) begin errors++; $display("FAIL mid_no_ack_in_dwell acks=%0d exp=0", acks); end
        tick();
        checks++; if (ack !== 2'b10 || grant_id !== 1'b1) begin errors++; $display("FAIL mid_ack1 ack=%b grant=%b exp 10/1", ack, grant_id); end
        req = 2'b00;
        frame1 = 32'hFFFF_FFFF;
        repeat (5) tick();
        checks++; if (led !== 8'hFF) begin errors++; $display("FAIL mid_lvl5_on got=%h exp=ff", led); end
        tick();
        checks++; if (led !== 8'h00) begin errors++; $display("FAIL mid_lvl5_off got=%h exp=00", led); end
    endtask

    task automatic test_levels();
        int bad;
        int odd_low;
        do_reset();
        frame0 = 32'hF0F0_F0F0;
        req    = 2'b01;
        repeat (16) tick();
        req     = 2'b00;
        bad     = 0;
        odd_low = 0;
        for (int i = 1; i <= 32; i++) begin
            tick();
            if ((led & 8'h55) !== 8'h00) bad++;
            if ((led & 8'hAA) !== 8'hAA) odd_low++;
            if (led !== ((ph == 4'd0) ? 8'h00 : 8'hAA)) bad++;
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL levels_pattern bad_cycles=%0d exp=0", bad); end
        checks++; if (odd_low != 2) begin errors++; $display("FAIL levels_15_low got=%0d exp=2", odd_low); end
    endtask

    task automatic test_reset_in_hold();
        int early;
        do_reset();
        frame0 = 32'h9999_9999;
        frame1 = 32'h6666_6666;
        req    = 2'b01;
        repeat (16) tick();
        req = 2'b00;
        repeat (43 * 16 + 3) tick();
        checks++; if (led !== 8'hFF || busy !== 1'b1) begin errors++; $display("FAIL rh_pre led=%h busy=%b exp ff/1", led, busy); end
        req   = 2'b10;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++; if (led !== 8'h00 || busy !== 1'b0 || ack !== 2'b00 || grant_id !== 1'b0)
            begin errors++; $display("FAIL rh_blank led=%h busy=%b ack=%b grant=%b exp 00/0/00/0", led, busy, ack, grant_id); end
        early = 0;
        for (int i = 1; i <= 15; i++) begin
            tick();
            if (ack !== 2'b00 || led !== 8'h00) early++;
        end
        checks++; if (early != 0) begin errors++; $display("FAIL rh_early bad_cycles=%0d exp=0", early); end
        tick();
        checks++; if (ack !== 2'b10 || grant_id !== 1'b1) begin errors++; $display("FAIL rh_ack1 ack=%b grant=%b exp 10/1", ack, grant_id); end
        req = 2'b00;
        repeat (6) tick();
        checks++; if (led !== 8'hFF) begin errors++; $display("FAIL rh_lvl6_on got=%h exp=ff", led); end
        tick();
        checks++; if (led !== 8'h00) begin errors++; $display("FAIL rh_lvl6_off got=%h exp=00", led); end
    endtask

    initial begin
        reset  = 1'b1;
        req    = 2'b00;
        frame0 = '0;
        frame1 = '0;
        ph     = 4'd0;
        test_reset();
        test_single();
        test_back_to_back();
        test_mid_dwell();
        test_levels();
        test_reset_in_hold();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
